// File: rtl/msx_bus_pkg.sv
// Shared types for the MSX slot-bus cycle detector: FSM states, cycle types,
// the idle bus data value and the combinational cycle qualifier.
package msx_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      STROBE,
      RD_WAIT,
      HOLD,
      RELEASE
   } state_t;

   typedef enum logic [2:0] {
      NONE,
      MR,
      MW,
      IR,
      IW
   } cyc_t;

   localparam logic [7:0] DATA_IDLE = 8'hFF;

   // Memory wins over I/O; rd_n and wr_n low together never qualify.
   // m1_n low with iorq_n marks an interrupt acknowledge, not an I/O read.
   function automatic cyc_t qualify(input logic sltsl_n,
                                    input logic iorq_n,
                                    input logic rd_n,
                                    input logic wr_n,
                                    input logic m1_n);
      cyc_t c;
      c = NONE;
      if (!sltsl_n && !rd_n && wr_n)
         c = MR;
      else if (!sltsl_n && !wr_n && rd_n)
         c = MW;
      else if (!iorq_n && !rd_n && wr_n && m1_n)
         c = IR;
      else if (!iorq_n && !wr_n && rd_n)
         c = IW;
      return c;
   endfunction

endpackage

// File: rtl/msx_bus_cycle_detector.sv
// Qualifies filtered MSX bus cycles into one-clk strobes and drives read data back onto the bus.
// Defining MSX_BUS_WAIT_EN adds wait_n, held low while read data is pending (bounded by RD_TIMEOUT).
module msx_bus_cycle_detector
   import msx_bus_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int RD_TIMEOUT    = 16,
   parameter int ADDR_W        = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sltsl_n,
   input  logic              iorq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              m1_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        din,
   input  logic [7:0]        rd_data,
   input  logic              rd_valid,
   output logic              mem_rd_stb,
   output logic              mem_wr_stb,
   output logic              io_rd_stb,
   output logic              io_wr_stb,
   output logic [ADDR_W-1:0] cyc_addr,
   output logic [7:0]        cyc_wdata,
   output logic [7:0]        dout,
   output logic              data_oe,
`ifdef MSX_BUS_WAIT_EN
   output logic              wait_n,
`endif
   output logic              busy
);

   localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);
   localparam logic [7:0] TMO_LIM    = 8'(RD_TIMEOUT - 1);

   state_t     state, nxt;
   cyc_t       cyc_type, cur;
   logic [3:0] cnt, cnt_inc;
   logic [7:0] tmo, tmo_inc;
   logic       sel_n;
   logic       is_rd;

   always_comb begin
      cur     = qualify(sltsl_n, iorq_n, rd_n, wr_n, m1_n);
      cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
      tmo_inc = (tmo == 8'hFF) ? tmo : tmo + 8'd1;
      is_rd   = (cyc_type == MR) || (cyc_type == IR);
      sel_n   = ((cyc_type == MR) || (cyc_type == MW)) ? sltsl_n : iorq_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (cur != NONE) nxt = SETTLE;
         SETTLE: begin
            if (cur != cyc_type)
               nxt = IDLE;
            else if (cnt_inc >= SETTLE_LIM)
               nxt = STROBE;
         end
         STROBE:  nxt = is_rd ? RD_WAIT : HOLD;
         // A host that gives up on the read wins over late or timed-out data.
         RD_WAIT: begin
            if (rd_n || sel_n)
               nxt = RELEASE;
            else if (rd_valid || (tmo >= TMO_LIM))
               nxt = HOLD;
         end
         HOLD:    if ((rd_n && wr_n) || sel_n) nxt = RELEASE;
         RELEASE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_type   <= NONE;
         cnt        <= 4'd0;
         tmo        <= 8'd0;
         mem_rd_stb <= 1'b0;
         mem_wr_stb <= 1'b0;
         io_rd_stb  <= 1'b0;
         io_wr_stb  <= 1'b0;
         cyc_addr   <= '0;
         cyc_wdata  <= 8'd0;
         dout       <= DATA_IDLE;
         data_oe    <= 1'b0;
`ifdef MSX_BUS_WAIT_EN
         wait_n     <= 1'b1;
`endif
      end else begin
         mem_rd_stb <= (state == STROBE) && (cyc_type == MR);
         mem_wr_stb <= (state == STROBE) && (cyc_type == MW);
         io_rd_stb  <= (state == STROBE) && (cyc_type == IR);
         io_wr_stb  <= (state == STROBE) && (cyc_type == IW);
         case (state)
            IDLE: begin
               if (cur != NONE) begin
                  cyc_type <= cur;
                  cnt      <= 4'd1;
               end
            end
            SETTLE: begin
               if (cur == cyc_type)
                  cnt <= cnt_inc;
               else
                  cnt <= 4'd0;
            end
            STROBE: begin
               cyc_addr <= addr;
               if (!is_rd)
                  cyc_wdata <= din;
               if (is_rd) begin
                  tmo     <= 8'd0;
                  data_oe <= 1'b1;
`ifdef MSX_BUS_WAIT_EN
                  wait_n  <= 1'b0;
`endif
               end
            end
            RD_WAIT: begin
               if (!(rd_n || sel_n)) begin
                  if (rd_valid)
                     dout <= rd_data;
                  else if (tmo >= TMO_LIM)
                     dout <= DATA_IDLE;
                  else
                     tmo <= tmo_inc;
               end
`ifdef MSX_BUS_WAIT_EN
               if (nxt != RD_WAIT)
                  wait_n <= 1'b1;
`endif
            end
            RELEASE: begin
               data_oe <= 1'b0;
               dout    <= DATA_IDLE;
               cnt     <= 4'd0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
